ballot_unit: RTL and testbench

Voter-side front end that drives the vote inputs and mode of the voting machine. Raw pushbuttons are synchronised and debounced. A ballot issued by the presiding officer arms the unit for exactly one vote, which appears as a single-cycle pulse on one candidate line. The unit then locks until the buttons are released and a new ballot is issued.

---
 rtl/ballot_unit_if.sv | 26 ++
 rtl/ballot_unit.sv | 130 +++++++++++++
 tb/tb_ballot_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ballot_unit_if.sv
// ballot_unit_if: officer/voting-machine side signals of the ballot unit.
// master drives poll control and ballots; slave is the ballot unit itself.
interface ballot_unit_if;
   logic       poll_open;
   logic       close_poll;
   logic       ballot_issue;
   logic [1:0] mode;
   logic       in_candidate_1;
   logic       in_candidate_2;
   logic       in_candidate_3;
   logic       ready;
   logic       vote_ack;
   logic       vote_timeout;

   modport master (
      output poll_open, close_poll, ballot_issue,
      input  mode, in_candidate_1, in_candidate_2, in_candidate_3,
      input  ready, vote_ack, vote_timeout
   );

   modport slave (
      input  poll_open, close_poll, ballot_issue,
      output mode, in_candidate_1, in_candidate_2, in_candidate_3,
      output ready, vote_ack, vote_timeout
   );
endinterface

// File: rtl/ballot_unit.sv
// ballot_unit: debounced voter front end issuing one vote pulse per ballot.
// Define BALLOT_TIMEOUT_EN to build the armed-ballot expiry timer.
module ballot_unit #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic         clk,
   input  logic         reset,
   ballot_unit_if.slave bus,
   input  logic         btn_1,
   input  logic         btn_2,
   input  logic         btn_3
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ARMED, RELEASE} state_t;

   state_t        state, state_next;
   logic [2:0]    btn_raw, sync_a, sync_b, deb, deb_q, press;
   logic [CW-1:0] cnt [3];
   logic [1:0]    mode;
   logic [2:0]    cand, cand_next;
   logic          ack, ack_next;
   logic          timeout, timeout_next;
   logic          expire, poll_closed;

   assign btn_raw = {btn_3, btn_2, btn_1};

   // Two-flop synchroniser, then a run-length counter per button.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_a <= '0;
         sync_b <= '0;
         deb    <= '0;
         deb_q  <= '0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
         deb_q  <= deb;
         for (int i = 0; i < 3; i++) begin
            if (sync_b[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               cnt[i] <= '0;
               deb[i] <= ~deb[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign press       = deb & ~deb_q;
   assign poll_closed = !bus.poll_open || bus.close_poll;

`ifdef BALLOT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] timer;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer <= '0;
      end else if (state != ARMED) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

   assign expire = (state == ARMED) && (timer == TW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign expire = 1'b0;
`endif

   // Poll close beats a vote, and a vote beats expiry in the same cycle.
   always_comb begin
      state_next   = state;
      cand_next    = '0;
      ack_next     = 1'b0;
      timeout_next = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ballot_issue && bus.poll_open && !bus.close_poll) state_next = ARMED;
         end
         ARMED: begin
            if (poll_closed) begin
               state_next = IDLE;
            end else if ($onehot(press)) begin
               cand_next  = press;
               ack_next   = 1'b1;
               state_next = RELEASE;
            end else if (expire) begin
               timeout_next = 1'b1;
               state_next   = IDLE;
            end
         end
         RELEASE: begin
            if (deb == 3'b000) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         mode    <= 2'd0;
         cand    <= '0;
         ack     <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_next;
         cand    <= cand_next;
         ack     <= ack_next;
         timeout <= timeout_next;
         mode    <= bus.close_poll ? 2'd2 : (bus.poll_open ? 2'd1 : 2'd0);
      end
   end

   assign bus.mode           = mode;
   assign bus.in_candidate_1 = cand[0];
   assign bus.in_candidate_2 = cand[1];
   assign bus.in_candidate_3 = cand[2];
   assign bus.ready          = (state == ARMED);
   assign bus.vote_ack       = ack;
   assign bus.vote_timeout   = timeout;
endmodule

// File: tb/tb_ballot_unit.sv
// tb_ballot_unit: directed scenarios plus random traffic checked cycle by cycle
// against a behavioural model of the ballot rules.
module tb_ballot_unit;
   localparam int DEB = 4;
   localparam int TMO = 20;
`ifdef BALLOT_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int PH_IDLE = 0, PH_ARMED = 1, PH_LOCKED = 2;

   logic clk = 1'b0;
   logic reset;
   logic btn_1, btn_2, btn_3;

   ballot_unit_if bus();

   ballot_unit #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .btn_1 (btn_1),
      .btn_2 (btn_2),
      .btn_3 (btn_3)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int votes = 0;
   int last_vote_cyc = 0;

   // Reference model state
   int         m_phase;
   int         m_age;
   bit [2:0]   m_deb, m_rose;
   int         m_run [3];
   bit [2:0]   raw_hist [$];
   logic [1:0] e_mode;
   logic [2:0] e_cand;
   logic       e_ack, e_tmo;

   task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   task automatic checkAllZero(string tag);
      checkOutput({tag, "_mode"},  bus.mode, 0);
      checkOutput({tag, "_cand1"}, bus.in_candidate_1, 0);
      checkOutput({tag, "_cand2"}, bus.in_candidate_2, 0);
      checkOutput({tag, "_cand3"}, bus.in_candidate_3, 0);
      checkOutput({tag, "_ready"}, bus.ready, 0);
      checkOutput({tag, "_ack"},   bus.vote_ack, 0);
      checkOutput({tag, "_tmo"},   bus.vote_timeout, 0);
   endtask

   task automatic modelReset();
      m_phase  = PH_IDLE;
      m_age    = 0;
      m_deb    = '0;
      m_rose   = '0;
      m_run    = '{default: 0};
      raw_hist = '{3'b000, 3'b000};
      e_mode   = '0;
      e_cand   = '0;
      e_ack    = 1'b0;
      e_tmo    = 1'b0;
   endtask

   // One clock edge of the ballot rules, using the inputs seen before the edge.
   task automatic modelEdge(bit po, bit cp, bit bi, bit [2:0] raw);
      bit [2:0] seen;
      int npress;
      npress = $countones(m_rose);
      e_cand = '0;
      e_ack  = 1'b0;
      e_tmo  = 1'b0;
      e_mode = cp ? 2'd2 : (po ? 2'd1 : 2'd0);
      case (m_phase)
         PH_IDLE: if (bi && po && !cp) begin m_phase = PH_ARMED; m_age = 0; end
         PH_ARMED: begin
            if (!po || cp) begin
               m_phase = PH_IDLE;
            end else if (npress == 1) begin
               e_cand  = m_rose;
               e_ack   = 1'b1;
               m_phase = PH_LOCKED;
            end else begin
               m_age++;
               if (TMO_EN && m_age == TMO) begin m_phase = PH_IDLE; e_tmo = 1'b1; end
            end
         end
         default: if (m_deb == 3'b000) m_phase = PH_IDLE;
      endcase
      seen = raw_hist.pop_front();
      raw_hist.push_back(raw);
      for (int i = 0; i < 3; i++) begin
         m_rose[i] = 1'b0;
         if (seen[i] != m_deb[i]) m_run[i]++;
         else m_run[i] = 0;
         if (m_run[i] == DEB) begin
            m_deb[i]  = ~m_deb[i];
            m_run[i]  = 0;
            m_rose[i] = m_deb[i];
         end
      end
   endtask

   task automatic applyStimulus(bit po, bit cp, bit bi, bit [2:0] b);
      @(negedge clk);
      bus.poll_open    = po;
      bus.close_poll   = cp;
      bus.ballot_issue = bi;
      {btn_3, btn_2, btn_1} = b;
      @(posedge clk);
      modelEdge(po, cp, bi, b);
      cyc++;
      #1;
      checkOutput("mode",  bus.mode, e_mode);
      checkOutput("cand1", bus.in_candidate_1, e_cand[0]);
      checkOutput("cand2", bus.in_candidate_2, e_cand[1]);
      checkOutput("cand3", bus.in_candidate_3, e_cand[2]);
      checkOutput("ready", bus.ready, (m_phase == PH_ARMED));
      checkOutput("ack",   bus.vote_ack, e_ack);
      checkOutput("tmo",   bus.vote_timeout, e_tmo);
      if (bus.in_candidate_1 || bus.in_candidate_2 || bus.in_candidate_3) begin
         votes++;
         last_vote_cyc = cyc;
      end
   endtask

   task automatic hold(int n, bit po, bit cp, bit [2:0] b);
      repeat (n) applyStimulus(po, cp, 1'b0, b);
   endtask

   initial begin
      int v0, press_cyc;
      bit po, cp;
      bit [2:0] b;

      reset = 1'b0;
      bus.poll_open = 1'b0;
      bus.close_poll = 1'b0;
      bus.ballot_issue = 1'b0;
      {btn_3, btn_2, btn_1} = 3'b000;
      modelReset();
      #3;
      checkAllZero("reset");
      #20;
      @(negedge clk);
      reset = 1'b1;

      // Mode tracking
      hold(3, 1'b0, 1'b0, 3'b000);
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'b000);
      hold(2, 1'b1, 1'b0, 3'b000);

      // Clean btn_2 vote and its press-to-pulse latency
      applyStimulus(1'b1, 1'b0, 1'b1, 3'b000);
      v0 = votes;
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b010);
      press_cyc = cyc;
      hold(9, 1'b1, 1'b0, 3'b010);
      checkOutput("t2_votes", votes - v0, 1);
      checkOutput("t2_latency", last_vote_cyc - press_cyc, DEB + 2);
      hold(8, 1'b1, 1'b0, 3'b000);

      // Glitchy btn_1 then a clean hold
      applyStimulus(1'b1, 1'b0, 1'b1, 3'b000);
      v0 = votes;
      repeat (3) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 3'b001);
         applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
      end
      hold(3, 1'b1, 1'b0, 3'b000);
      checkOutput("t3_glitch_votes", votes - v0, 0);
      hold(8, 1'b1, 1'b0, 3'b001);
      checkOutput("t3_clean_votes", votes - v0, 1);
      hold(8, 1'b1, 1'b0, 3'b000);

      // Idle armed ballot, then a press without a new ballot
      applyStimulus(1'b1, 1'b0, 1'b1, 3'b000);
      hold(TMO + 4, 1'b1, 1'b0, 3'b000);
      v0 = votes;
      hold(8, 1'b1, 1'b0, 3'b001);
      checkOutput("t4_late_votes", votes - v0, TMO_EN ? 0 : 1);
      hold(8, 1'b1, 1'b0, 3'b000);

      // Double press, release, btn_3 vote landing on the expiry edge
      applyStimulus(1'b1, 1'b0, 1'b1, 3'b000);
      v0 = votes;
      hold(7, 1'b1, 1'b0, 3'b101);
      checkOutput("t5_double_votes", votes - v0, 0);
      checkOutput("t5_ready", bus.ready, 1);
      hold(6, 1'b1, 1'b0, 3'b000);
      hold(7, 1'b1, 1'b0, 3'b100);
      checkOutput("t5_votes", votes - v0, 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 3'b100);
      checkOutput("t5_locked_ready", bus.ready, 0);
      hold(8, 1'b1, 1'b0, 3'b000);

      // Button held before arming, then reset mid-debounce
      hold(8, 1'b1, 1'b0, 3'b010);
      applyStimulus(1'b1, 1'b0, 1'b1, 3'b010);
      hold(6, 1'b1, 1'b0, 3'b000);
      hold(3, 1'b1, 1'b0, 3'b010);
      reset = 1'b0;
      #1;
      checkAllZero("t6_reset");
      modelReset();
      @(negedge clk);
      reset = 1'b1;
      v0 = votes;
      hold(10, 1'b1, 1'b0, 3'b010);
      checkOutput("t6_votes", votes - v0, 0);
      hold(8, 1'b1, 1'b0, 3'b000);

      // Random traffic
      po = 1'b1;
      cp = 1'b0;
      b  = 3'b000;
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(39) == 0) po = ~po;
         if (cp) cp = ($urandom_range(3) != 0);
         else    cp = ($urandom_range(59) == 0);
         for (int i = 0; i < 3; i++) if ($urandom_range(11) == 0) b[i] = ~b[i];
         applyStimulus(po, cp, ($urandom_range(7) == 0), b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
